// File: rtl/fifo_bank_pkg.sv
// Shared constants and width helpers for the per-channel FIFO bank.
package fifo_bank_pkg;

  localparam int unsigned DEF_NUM_CH    = 10;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_DEPTH     = 16;
  localparam int unsigned DEF_AF_THRESH = 12;

  // Ceiling log2 for elaboration-time width derivation.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Pointer width; a depth of 1 would otherwise give a zero-width pointer.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth < 2) ? 1 : clog2(depth);
  endfunction

  // Occupancy width: must hold 0..DEPTH inclusive.
  function automatic int unsigned level_w(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_chan.sv
// One single-clock FIFO channel with level, almost-full, sticky error flags,
// flush and selectable registered / show-ahead read.
module fifo_chan
  import fifo_bank_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AF_THRESH = DEF_AF_THRESH,
  parameter int unsigned FWFT      = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           din,
  input  logic                        rd_en,
  input  logic                        flush,
  input  logic                        clr_err,
  output logic [DATA_W-1:0]           dout,
  output logic                        empty,
  output logic                        full,
  output logic                        afull,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        ovf,
  output logic                        udf
);

  localparam int unsigned AW = addr_w(DEPTH);
  localparam int unsigned LW = level_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic              ovf_set;
  logic              udf_set;
  logic [LW-1:0]     level_nxt;

  // Acceptance and error detection from the registered flags; flush masks all.
  always_comb begin
    wr_acc    = wr_en & ~full  & ~flush;
    rd_acc    = rd_en & ~empty & ~flush;
    ovf_set   = wr_en & full   & ~flush;
    udf_set   = rd_en & empty  & ~flush;
    level_nxt = level + LW'(wr_acc) - LW'(rd_acc);
    if (flush) level_nxt = '0;
  end

  // Pointers, level and flags; flags derive from the next level so they track it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      afull  <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
        if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == LW'(DEPTH));
      afull <= (level_nxt >= LW'(AF_THRESH));
      ovf   <= ovf_set | (ovf & ~clr_err);
      udf   <= udf_set | (udf & ~clr_err);
    end
  end

  // Storage array, not reset; words are only visible through level.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Show-ahead: head word driven straight from the registered read pointer.
      assign dout = mem[rd_ptr];
    end else begin : g_reg
      // Registered read: data appears the cycle after an accepted pop.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         dout <= '0;
        else if (rd_acc) dout <= mem[rd_ptr];
      end
    end
  endgenerate

endmodule

// File: rtl/fifo_bank.sv
// Bank of NUM_CH independent FIFO channels on packed per-channel buses.
module fifo_bank
  import fifo_bank_pkg::*;
#(
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AF_THRESH = DEF_AF_THRESH,
  parameter int unsigned FWFT      = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CH-1:0]                   wr_en,
  input  logic [NUM_CH*DATA_W-1:0]            din,
  input  logic [NUM_CH-1:0]                   rd_en,
  output logic [NUM_CH*DATA_W-1:0]            dout,
  output logic [NUM_CH-1:0]                   empty,
  output logic [NUM_CH-1:0]                   full,
  output logic [NUM_CH-1:0]                   afull,
  output logic [NUM_CH*level_w(DEPTH)-1:0]    level,
  output logic [NUM_CH-1:0]                   ovf,
  output logic [NUM_CH-1:0]                   udf,
  input  logic [NUM_CH-1:0]                   flush,
  input  logic [NUM_CH-1:0]                   clr_err
);

  localparam int unsigned LW = level_w(DEPTH);

  // One channel per slice of the packed buses.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    fifo_chan #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH),
      .FWFT      (FWFT)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[ch]),
      .din     (din[ch*DATA_W +: DATA_W]),
      .rd_en   (rd_en[ch]),
      .flush   (flush[ch]),
      .clr_err (clr_err[ch]),
      .dout    (dout[ch*DATA_W +: DATA_W]),
      .empty   (empty[ch]),
      .full    (full[ch]),
      .afull   (afull[ch]),
      .level   (level[ch*LW +: LW]),
      .ovf     (ovf[ch]),
      .udf     (udf[ch])
    );
  end

endmodule

// File: doc/fifo_bank.md
Name: fifo_bank

Overview:
Parametrised bank of NUM_CH independent single-clock FIFOs for buffering per-bit-plane coded bytes between the BPC context stage and the MQ coder.
- Successor to the fixed 10×8-bit dual-clock FIFO bank.
- Generalised in channel count, data width and depth.
- Adds per-channel fill level, almost-full, sticky overflow/underflow error flags, per-channel flush, and a selectable show-ahead (FWFT) read mode.

Parameters:
NUM_CH, 10, number of independent channels
DATA_W, 8, data width per channel in bits
DEPTH, 16, entries per channel; power of 2, >= 2
AF_THRESH, 12, afull asserts when level >= AF_THRESH; range 1..DEPTH
FWFT, 0, 0 = registered read (data one cycle after rd_en); 1 = show-ahead (head word valid whenever not empty)
(derived, not overridable) AW = log2(DEPTH); LW = AW+1

Ports:
clk      in   1            single clock; all logic on rising edge
rst      in   1            asynchronous reset, active-high
wr_en    in   NUM_CH       per-channel write request
din      in   NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
rd_en    in   NUM_CH       per-channel read (pop) request
dout     out  NUM_CH*DATA_W  read data, same packing as din
empty    out  NUM_CH       channel level == 0
full     out  NUM_CH       channel level == DEPTH
afull    out  NUM_CH       channel level >= AF_THRESH
level    out  NUM_CH*LW    current occupancy per channel, 0..DEPTH
ovf      out  NUM_CH       sticky: write attempted while full and not accepted
udf      out  NUM_CH       sticky: read attempted while empty
flush    in   NUM_CH       synchronous per-channel clear of contents
clr_err  in   NUM_CH       synchronous per-channel clear of ovf/udf

Behaviour:
- Reset (rst=1, async): wr/rd pointers 0, level 0, empty all 1s, full/afull/ovf/udf 0, dout 0. Storage contents are not reset.
- Channels are fully independent. All rules below apply per channel.
- Write acceptance: wr_acc = wr_en & ~full, with full sampled before the edge. Accepted data is stored at wr_ptr; wr_ptr increments mod DEPTH.
- Read acceptance: rd_acc = rd_en & ~empty, with empty sampled before the edge. rd_ptr increments mod DEPTH.
- level next = level + wr_acc - rd_acc.
- Simultaneous wr_en and rd_en:
  - when full: read accepted, write dropped, ovf set, level becomes DEPTH-1.
  - when empty: write accepted, read rejected, udf set, level becomes 1.
  - otherwise: both accepted, level unchanged.
- Flags are registered and consistent with level in the same cycle: empty=(level==0), full=(level==DEPTH), afull=(level>=AF_THRESH).
- Pointers are AW bits and wrap naturally. Full/empty come from level, not from pointer comparison.
- FWFT=0:
  - on rd_acc, dout <= mem[rd_ptr] at that edge, so valid the cycle after rd_en.
  - dout holds its value otherwise, including after reads on empty.
- FWFT=1:
  - dout = mem[rd_ptr], combinational from the registered pointer.
  - valid whenever empty=0; rd_en pops the current word.
  - A write into an empty channel makes the word visible the cycle after the write edge, when empty drops.
  - dout is don't-care while empty.
- flush: next edge sets wr_ptr=rd_ptr=0 and level=0. Writes and reads in the same cycle are ignored and set no flags. ovf/udf are unaffected.
- clr_err clears ovf/udf at the next edge. If a new error occurs in the same cycle, the error wins (flag stays 1).
- Reset mid-operation: all state returns to reset values immediately. No partial write completes.

Decomposition:
- Package fifo_bank_pkg: clog2 function; AW/LW derivation; default constants (DEF_NUM_CH=10, DEF_DATA_W=8, DEF_DEPTH=16).
- Sub-module fifo_chan: one channel, carrying DATA_W, DEPTH, AF_THRESH and FWFT.
- fifo_bank instantiates NUM_CH fifo_chan in a generate loop and slices the packed buses.
- Storage is an inferred register array, DEPTH×DATA_W, per channel.

Test Plan:
1. Reset then idle: rst pulse -> empty=10'h3FF, full=0, afull=0, level all 0, ovf=udf=0, dout=0.
2. Fill ch3 with 0x00..0x0F, 16 writes -> level[3] counts 1..16, afull[3] rises on the 12th write, full[3] on the 16th. A 17th write (0xAA) sets ovf[3] and level stays 16. Then 16 reads return 0x00..0x0F in order; the FWFT=0 build shows each word one cycle after rd_en.
3. Read empty ch0 -> udf[0]=1, level 0. clr_err[0] -> udf[0]=0 next cycle. clr_err together with another empty read -> udf stays 1.
4. Simultaneous on ch5:
   - empty with wr 0x55 + rd -> level 1, udf=1, data 0x55 readable afterwards.
   - full with wr + rd -> oldest word popped, level 15, ovf=1.
   - mid-level (8) with wr + rd -> level stays 8.
5. Wrap and flush: 40 interleaved write/read pairs on ch9 with pointer wrap -> data order preserved. Then load 5 words and assert flush[9] together with wr_en -> level 0, empty=1, flushed word not stored. Other channels unchanged throughout.
6. FWFT=1, DEPTH=4, NUM_CH=2: write 0x11 to ch1 -> next cycle empty=0, dout ch1=0x11 with no rd_en. Pop -> empty=1. Assert rst mid-burst -> all flags return to reset values immediately.
